// File: rtl/cpu_seq_ctrl_if.sv
// Control bundle between the sequencer (master) and the CPU datapath (slave).
// Strobes and the retired count flow to the datapath; run/opcode/zero flow back.
interface cpu_seq_ctrl_if #(
  parameter int OP_W  = 3,
  parameter int CNT_W = 8
);
  logic             run;
  logic [OP_W-1:0]  opcode;
  logic             zero;
  logic             pc_inc;
  logic             pc_load;
  logic             ir_load;
  logic             addr_sel;
  logic             mem_we;
  logic             rf_we;
  logic             wb_sel;
  logic [1:0]       alu_op;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, opcode, zero,
    output pc_inc, pc_load, ir_load, addr_sel, mem_we, rf_we, wb_sel,
           alu_op, halted, retired
  );

  modport slave (
    output run, opcode, zero,
    input  pc_inc, pc_load, ir_load, addr_sel, mem_we, rf_we, wb_sel,
           alu_op, halted, retired
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-word x 9-bit CPU.
// Retires one instruction at a time, counts retirements, and parks in S_HALT.
module cpu_seq_ctrl #(
  parameter int OP_W  = 3,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  cpu_seq_ctrl_if.master    bus
);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LDR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BZ   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_STR  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(7);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_LOADIR = 3'd1,
    S_DECODE = 3'd2,
    S_ALU    = 3'd3,
    S_MEMRD  = 3'd4,
    S_WBMEM  = 3'd5,
    S_MEMWR  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic             retire;
  logic [CNT_W-1:0] retired_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next state and retire event
  always_comb begin
    state_d = S_FETCH;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = bus.run ? S_LOADIR : S_FETCH;
      S_LOADIR: state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_ADD, OP_SUB: state_d = S_ALU;
          OP_LDR:         state_d = S_MEMRD;
          OP_STR:         state_d = S_MEMWR;
          OP_HALT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          default: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      S_ALU: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMRD:  state_d = S_WBMEM;
      S_WBMEM, S_MEMWR: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode; IR and zero are both registered, so pc_load stays glitch-free
  always_comb begin
    bus.pc_inc   = 1'b0;
    bus.pc_load  = 1'b0;
    bus.ir_load  = 1'b0;
    bus.addr_sel = 1'b0;
    bus.mem_we   = 1'b0;
    bus.rf_we    = 1'b0;
    bus.wb_sel   = 1'b0;
    bus.alu_op   = 2'b00;
    bus.halted   = 1'b0;
    case (state_q)
      S_LOADIR: begin
        bus.ir_load = 1'b1;
        bus.pc_inc  = 1'b1;
      end
      S_DECODE: bus.pc_load = (bus.opcode == OP_BZ) && bus.zero;
      S_ALU: begin
        bus.alu_op = (bus.opcode == OP_SUB) ? 2'b10 : 2'b01;
        bus.rf_we  = 1'b1;
      end
      S_MEMRD:  bus.addr_sel = 1'b1;
      S_WBMEM: begin
        bus.addr_sel = 1'b1;
        bus.rf_we    = 1'b1;
        bus.wb_sel   = 1'b1;
      end
      S_MEMWR: begin
        bus.addr_sel = 1'b1;
        bus.mem_we   = 1'b1;
      end
      S_HALT:   bus.halted = 1'b1;
      default: ;
    endcase
  end

  // Retired-instruction counter, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      retired_q <= '0;
    else if (retire) retired_q <= sat_inc(retired_q);
  end

  assign bus.retired = retired_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: a small datapath stand-in plus an instruction-level
// reference model checked every cycle, with directed literal checks on top.
module tb_cpu_seq_ctrl;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [2:0] ADD = 3'd2, SUB = 3'd3, LDR = 3'd4, BZ = 3'd5,
                         STR = 3'd6, HLT = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cpu_seq_ctrl_if #(.OP_W(3), .CNT_W(CNT_W)) bus ();
  cpu_seq_ctrl #(.OP_W(3), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Datapath stand-in: program ROM, PC, IR, and strobe counters
  logic [8:0] prog [8];
  logic [2:0] pc;
  logic [8:0] ir;
  int wr_cnt = 0;
  int ldwb_cnt = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= 3'd0;
      ir <= 9'd0;
    end else begin
      if (bus.pc_load)     pc <= ir[2:0];
      else if (bus.pc_inc) pc <= pc + 3'd1;
      if (bus.ir_load)     ir <= prog[pc];
    end
  end

  always @(posedge clk) begin
    if (reset && bus.mem_we)              wr_cnt   <= wr_cnt + 1;
    if (reset && bus.rf_we && bus.wb_sel) ldwb_cnt <= ldwb_cnt + 1;
  end

  assign bus.opcode = ir[8:6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ilen(input logic [2:0] op);
    case (op)
      ADD, SUB, STR: return 4;
      LDR:           return 5;
      default:       return 3;
    endcase
  endfunction

  // Reference model: position inside the current instruction plus its opcode
  int         m_pos  = 0;
  bit         m_halt = 1'b0;
  int         m_ret  = 0;
  logic [2:0] m_pc   = 3'd0;
  logic [8:0] m_ir   = 9'd0;

  always @(negedge clk) begin : model
    logic [2:0] op;
    logic       e_inc, e_pcl, e_irl, e_asel, e_mwe, e_rfwe, e_wb, e_halt;
    logic [1:0] e_alu;
    logic [9:0] e_vec, a_vec;
    a_vec = {bus.pc_inc, bus.pc_load, bus.ir_load, bus.addr_sel, bus.mem_we,
             bus.rf_we, bus.wb_sel, bus.alu_op, bus.halted};
    if (!reset) begin
      m_pos = 0; m_halt = 1'b0; m_ret = 0; m_pc = 3'd0; m_ir = 9'd0;
      chk("reset_strobes", 32'(a_vec), 32'd0);
      chk("reset_retired", 32'(bus.retired), 32'd0);
    end else begin
      op = m_ir[8:6];
      {e_inc, e_pcl, e_irl, e_asel, e_mwe, e_rfwe, e_wb, e_halt} = '0;
      e_alu = 2'b00;
      if (m_halt) e_halt = 1'b1;
      else begin
        case (m_pos)
          1: begin e_irl = 1'b1; e_inc = 1'b1; end
          2: e_pcl = (op == BZ) && bus.zero;
          3: begin
            if (op == ADD || op == SUB) begin
              e_alu = (op == SUB) ? 2'b10 : 2'b01;
              e_rfwe = 1'b1;
            end else begin
              e_asel = 1'b1;
              e_mwe  = (op == STR);
            end
          end
          4: begin e_asel = 1'b1; e_rfwe = 1'b1; e_wb = 1'b1; end
          default: ;
        endcase
      end
      e_vec = {e_inc, e_pcl, e_irl, e_asel, e_mwe, e_rfwe, e_wb, e_alu, e_halt};
      if (m_pos == 0 && !m_halt) chk("fetch_pc", 32'(pc), 32'(m_pc));
      chk("strobes", 32'(a_vec), 32'(e_vec));
      chk("retired", 32'(bus.retired), 32'(m_ret));
      // advance to the state expected after the coming rising edge
      if (!m_halt) begin
        if (m_pos == 0) begin
          if (bus.run) m_pos = 1;
        end else if (m_pos == 1) begin
          m_ir  = prog[m_pc];
          m_pc  = m_pc + 3'd1;
          m_pos = 2;
        end else begin
          if (m_pos == 2 && op == BZ && bus.zero) m_pc = m_ir[2:0];
          if (m_pos + 1 == ilen(op)) begin
            m_ret = (m_ret >= CNT_MAX) ? CNT_MAX : m_ret + 1;
            m_pos = 0;
            if (op == HLT) m_halt = 1'b1;
          end else begin
            m_pos = m_pos + 1;
          end
        end
      end
    end
  end

  // Caller is at posedge+1 with the sequencer in S_FETCH
  task automatic exec_one(input int exp_cyc, input logic z, input string name);
    logic [CNT_W-1:0] r0;
    int n;
    r0 = bus.retired;
    n = 0;
    bus.zero = z;
    bus.run  = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.retired == r0 && n < 20);
    bus.run = 1'b0;
    chk({name, "_cycles"}, 32'(n), 32'(exp_cyc));
  endtask

  task automatic pulse_reset();
    reset   = 1'b0;
    bus.run = 1'b0;
    @(negedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int w0, l0;
    bus.run  = 1'b0;
    bus.zero = 1'b0;
    for (int i = 0; i < 8; i++) prog[i] = 9'd0;
    prog[1] = 9'b100101010;
    prog[2] = 9'b110111000;
    prog[3] = 9'b101000110;
    prog[7] = 9'b101000110;

    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // Directed program: NOP, LDR, STR, BZ taken, NOP, BZ not taken at PC=7
    exec_one(3, 1'b0, "nop");
    chk("nop_retired", 32'(bus.retired), 32'd1);
    chk("nop_pc", 32'(pc), 32'd1);
    l0 = ldwb_cnt;
    exec_one(5, 1'b0, "ldr");
    chk("ldr_wb_count", 32'(ldwb_cnt - l0), 32'd1);
    chk("ldr_pc", 32'(pc), 32'd2);
    w0 = wr_cnt;
    exec_one(4, 1'b0, "str");
    chk("str_we_count", 32'(wr_cnt - w0), 32'd1);
    exec_one(3, 1'b1, "bz_taken");
    chk("bz_taken_pc", 32'(pc), 32'd6);
    exec_one(3, 1'b0, "nop6");
    exec_one(3, 1'b0, "bz_wrap");
    chk("bz_wrap_pc", 32'(pc), 32'd0);
    chk("seq_retired", 32'(bus.retired), 32'd6);

    // Stall between instructions
    repeat (6) begin @(posedge clk); #1; end
    chk("stall_retired", 32'(bus.retired), 32'd6);
    chk("stall_pc", 32'(pc), 32'd0);

    // Reset asserted in the middle of S_MEMWR
    prog[0] = 9'b110111000;
    w0 = wr_cnt;
    bus.run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("memwr_we", 32'(bus.mem_we), 32'd1);
    reset = 1'b0;
    bus.run = 1'b0;
    #1;
    chk("rst_we_drop", 32'(bus.mem_we), 32'd0);
    chk("rst_addr_sel", 32'(bus.addr_sel), 32'd0);
    @(negedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_retired", 32'(bus.retired), 32'd0);
    chk("rst_no_write", 32'(wr_cnt - w0), 32'd0);

    // HALT then run toggling
    prog[0] = 9'b111001111;
    exec_one(3, 1'b0, "halt");
    chk("halt_flag", 32'(bus.halted), 32'd1);
    repeat (12) begin
      @(posedge clk); #1;
      bus.run = 1'($urandom_range(0, 1));
    end
    chk("halt_retired", 32'(bus.retired), 32'd1);
    chk("halt_hold", 32'(bus.halted), 32'd1);
    chk("halt_pc", 32'(pc), 32'd1);

    // Saturation: only 3-cycle instructions, run held high
    for (int i = 0; i < 8; i++) prog[i] = (i % 2 == 0) ? 9'b000000000 : 9'b101000011;
    pulse_reset();
    bus.run = 1'b1;
    repeat (850) begin
      @(posedge clk); #1;
      bus.zero = 1'($urandom_range(0, 1));
    end
    chk("sat_retired", 32'(bus.retired), 32'(CNT_MAX));
    bus.run = 1'b0;

    // Randomized programs with random run/zero and periodic resets
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 8; i++) prog[i] = 9'($urandom);
      pulse_reset();
      repeat (150) begin
        bus.run  = ($urandom_range(0, 3) != 0);
        bus.zero = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
